// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiplier/divider (RV32M/RV64M style ops), fixed XLEN+2 latency
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [XLEN-1:0] a_q, m;
  logic [2*XLEN-1:0] p, p_step, prod;
  logic na_q, nb_q, bz;
  logic sa, sb, na, nb;
  logic [XLEN-1:0] ma, mb, quo, rem_v, res_fix;
  logic [XLEN:0] sum, sh, diff;
  always_comb begin
    sa = func3[2] ? ~func3[0] : func3[1:0] != 2'b11;
    sb = func3[2] ? ~func3[0] : ~func3[1];
    na = sa & a[XLEN-1];
    nb = sb & b[XLEN-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    sum = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, (p[0] ? m : {XLEN{1'b0}})};
    sh = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff = sh - {1'b0, m};
    // divide: high half holds the partial remainder, low half shifts in quotient bits
    p_step = op[2] ? (diff[XLEN] ? {sh[XLEN-1:0], p[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1})
                   : {sum, p[XLEN-1:1]};
    prod = (na_q ^ nb_q) ? -p : p;
    quo = (na_q ^ nb_q) ? -p[XLEN-1:0] : p[XLEN-1:0];
    rem_v = na_q ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    res_fix = !op[2] ? (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
            : bz ? (op[1] ? a_q : {XLEN{1'b1}})
            : op[1] ? rem_v : quo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cnt <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op <= func3;
          a_q <= a;
          na_q <= na;
          nb_q <= nb;
          bz <= b == '0;
          m <= func3[2] ? mb : ma;
          p <= {{XLEN{1'b0}}, (func3[2] ? ma : mb)};
          cnt <= '0;
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          p <= p_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= res_fix;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed + random checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] func3 = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] result;
  logic start8 = 1'b0, flush8 = 1'b0;
  logic [2:0] f8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8;
  logic [7:0] result8;
  int total = 0, bad = 0;
  logic [31:0] last_exp = '0;

  mul_div_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .start(start), .func3(func3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result));
  mul_div_unit #(.XLEN(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .func3(f8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .result(result8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    if (!f[2]) begin
      r = f == 3'd0 || f == 3'd1 ? sx * sy : f == 3'd2 ? sx * uy : ux * uy;
      return f == 3'd0 ? r[31:0] : r[63:32];
    end
    if (y == 0) return f[1] ? x : 32'hFFFF_FFFF;
    case (f)
      3'd4: r = sx / sy;
      3'd5: r = ux / uy;
      3'd6: r = sx % sy;
      default: r = ux % uy;
    endcase
    return r[31:0];
  endfunction

  // Issue one op from IDLE; check latency, busy coverage, result and the single-cycle done pulse.
  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input string tag);
    int n;
    logic busy_ok;
    start = 1'b1; func3 = f; a = x; b = y;
    tick();
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      busy_ok &= busy;
      tick();
      n++;
    end
    busy_ok &= busy;
    last_exp = model(f, x, y);
    chk({tag, " latency"}, 64'(n), 64'd34);
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(last_exp));
    tick();
    chk({tag, " done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int dones, n;
    logic seen;
    logic [2:0] rf;
    logic [31:0] rx, ry;
    tick(); tick();
    chk("reset", {31'd0, busy, done, result}, 64'd0);
    rst = 1'b0;
    tick();
    run(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    chk("mul_7x-3 const", 64'(result), 64'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    chk("mulh_min const", 64'(result), 64'h4000_0000);
    run(3'd3, 32'h8000_0000, 32'h8000_0000, "mulhu");
    run(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    chk("mulhsu const", 64'(result), 64'hFFFF_FFFF);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    chk("div_-7/2 const", 64'(result), 64'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7/2");
    run(3'd5, 32'd100, 32'd7, "divu");
    chk("divu const", 64'(result), 64'd14);
    run(3'd7, 32'd100, 32'd7, "remu");
    run(3'd5, 32'd5, 32'd0, "divu_by0");
    run(3'd6, 32'd5, 32'd0, "rem_by0");
    run(3'd4, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
    run(3'd7, 32'hFFFF_FFF9, 32'd0, "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf const", 64'(result), 64'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    repeat (48) begin
      rf = 3'($urandom_range(0, 7));
      rx = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
      ry = $urandom_range(0, 5) == 0 ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      run(rf, rx, ry, "random");
    end
    // flush mid-multiply: no done, result retained
    start = 1'b1; func3 = 3'd0; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin seen |= done; tick(); end
    chk("flush no_done", 64'(seen), 64'd0);
    chk("flush result", 64'(result), 64'(last_exp));
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_wins busy", 64'(busy), 64'd0);
    // start while busy is dropped
    start = 1'b1; func3 = 3'd5; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; func3 = 3'd0; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0;
    dones = 0;
    repeat (70) begin dones += int'(done); tick(); end
    chk("busy_start dones", 64'(dones), 64'd1);
    chk("busy_start result", 64'(result), 64'd14);
    // reset mid-divide
    start = 1'b1; func3 = 3'd4; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid state", {31'd0, busy, done, result}, 64'd0);
    seen = 1'b0;
    repeat (40) begin seen |= done; tick(); end
    chk("rst_mid no_done", 64'(seen), 64'd0);
    run(3'd6, 32'd1000, 32'd3, "after_rst");
    // XLEN=8 overflow divide
    start8 = 1'b1; f8 = 3'd4; a8 = 8'h80; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 30) begin tick(); n++; end
    chk("x8 latency", 64'(n), 64'd10);
    chk("x8 result", 64'(result8), 64'h80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
